cwmac_tag_verifier: RTL and testbench
=====================================

Name: cwmac_tag_verifier

Overview:
Read-side counterpart of the CWMACOpt tag generator. It accepts a verify request carrying a line's address, nonce, ciphertext message and the stored tag fetched from memory. It drives the request into a CWMACOpt instance, collects the recomputed tag, compares it against the stored tag, and returns a pass/fail/timeout response. It sits between the memory-read path and the integrity-violation reporting logic.

Parameters:
ADDR_W, 26, line address width (matches io_source_bits_addr)
NONCE_W, 56, nonce width
MSG_W, 512, message (cache line) width
TAG_W, 56, tag width
TIMEOUT, 255, maximum cycles spent waiting for the MAC tag; legal range 1..65535

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
io_req_valid  in  1  verify request valid
io_req_ready  out  1  verifier can accept a request
io_req_bits_addr  in  ADDR_W  line address
io_req_bits_nonce  in  NONCE_W  nonce
io_req_bits_msg  in  MSG_W  message
io_req_bits_tag  in  TAG_W  stored tag to check against
io_mac_source_valid  out  1  one-cycle pulse to the MAC engine (no ready exists on that port)
io_mac_source_bits_addr  out  ADDR_W  registered address to the MAC
io_mac_source_bits_nonce  out  NONCE_W  registered nonce to the MAC
io_mac_source_bits_msg  out  MSG_W  registered message to the MAC
io_mac_tag_bits  in  TAG_W  computed tag from the MAC
io_mac_tag_valid  in  1  computed tag valid
io_mac_tag_ready  out  1  verifier accepts the computed tag
io_resp_valid  out  1  response valid
io_resp_ready  in  1  response consumer ready
io_resp_bits_ok  out  1  stored tag equals computed tag
io_resp_bits_timeout  out  1  no tag arrived within TIMEOUT cycles
io_resp_bits_tag  out  TAG_W  computed tag (0 on timeout)
io_failCount  out  16  saturating count of non-ok responses delivered
io_staleDrop  out  1  pulses for one cycle when a MAC tag arrives outside WAIT and is discarded

Behaviour:
- The state machine has four states: IDLE, ISSUE, WAIT, RESP. Reset puts it in IDLE.
- Values while reset is asserted:
  - io_req_ready = 0 and io_mac_tag_ready = 0. Both are registered and go to 1 on the first cycle after reset deasserts.
  - All other outputs are 0 and io_failCount = 0.
- io_mac_tag_ready is 1 in every state after reset.
- IDLE:
  - io_req_ready = 1.
  - On io_req_valid, latch addr, nonce, msg and stored tag into registers, then go to ISSUE.
- ISSUE:
  - io_mac_source_valid = 1 for exactly this one cycle, driving the latched fields.
  - Clear the wait counter to 0, then go to WAIT.
  - io_req_ready = 0 in every state except IDLE.
- WAIT:
  - On io_mac_tag_valid, capture the tag, set ok = (tag == stored tag) and timeout = 0, then go to RESP.
  - Otherwise increment the 16-bit wait counter. When the counter equals TIMEOUT-1 with no tag that cycle, set ok = 0, timeout = 1 and tag = 0, then go to RESP.
  - If a tag arrives on the same cycle the timeout would fire, the tag wins.
- RESP:
  - io_resp_valid = 1. io_resp_bits_* are held stable until the cycle where io_resp_ready is 1.
  - After that handshake, go to IDLE.
  - If the handshake has ok = 0, io_failCount increments, saturating at 16'hFFFF.
- Any io_mac_tag_valid in IDLE, ISSUE or RESP is consumed and discarded, and io_staleDrop = 1 for that cycle. This covers late tags after a timeout. io_failCount is not affected.
- Minimum latency, with the request accepted in cycle T:
  - io_mac_source_valid in T+1.
  - The earliest tag that is accepted arrives in T+2.
  - io_resp_valid in T+3.
  - The next request can be accepted no earlier than T+4 with io_resp_ready held at 1.
- Reset mid-operation: return to IDLE on the next edge. The in-flight request is dropped with no response, and the counters and io_failCount are cleared.
- Tag comparison is a full TAG_W-bit equality check; there is no masking.

Test Plan:
- Match: request addr 26'h11ffe00, nonce 56'h2, msg 512'h…0100…0002 (the known vector), stored tag 56'h9d906ad9445061; MAC model returns 56'h9d906ad9445061 two cycles after the source pulse -> exactly one io_mac_source_valid pulse carrying those fields; io_resp_valid with ok=1, timeout=0, tag=56'h9d906ad9445061; io_failCount stays 0.
- Mismatch: same request with stored tag 56'h9d906ad9445060 -> ok=0, timeout=0, tag=56'h9d906ad9445061; io_failCount=1 after the handshake.
- Timeout: TIMEOUT=8, MAC never responds -> io_resp_valid rises exactly 8 cycles after entering WAIT with ok=0, timeout=1, tag=0. A tag injected 3 cycles later -> io_staleDrop pulses once; state remains IDLE.
- Backpressure: io_resp_ready held 0 for 5 cycles -> response fields stable and io_req_ready=0 throughout; new io_req_valid ignored until the handshake, then accepted the following cycle.
- Tag/timeout tie: TIMEOUT=4, tag arrives on the 4th WAIT cycle -> ok reflects the comparison, timeout=0.
- Reset in WAIT and failCount saturation: assert reset while in WAIT -> io_resp_valid never asserts, io_failCount=0, io_req_ready=1 one cycle after release. Preload via 65535 mismatches (or force) -> io_failCount holds at 16'hFFFF after further mismatches.

Source files
------------

// File: rtl/cwmac_tag_verifier.sv
// Read-side tag verifier: drives one request into a CWMACOpt engine, waits for the
// recomputed tag (or a timeout), and returns a pass/fail/timeout response.
// Handshakes: req and resp transfer on a cycle where valid && ready are both high;
// valid never depends on ready, and resp payload is held stable until it transfers.
module cwmac_tag_verifier #(
    parameter int ADDR_W  = 26,
    parameter int NONCE_W = 56,
    parameter int MSG_W   = 512,
    parameter int TAG_W   = 56,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_req_valid,
    output logic               io_req_ready,
    input  logic [ADDR_W-1:0]  io_req_bits_addr,
    input  logic [NONCE_W-1:0] io_req_bits_nonce,
    input  logic [MSG_W-1:0]   io_req_bits_msg,
    input  logic [TAG_W-1:0]   io_req_bits_tag,
    output logic               io_mac_source_valid,
    output logic [ADDR_W-1:0]  io_mac_source_bits_addr,
    output logic [NONCE_W-1:0] io_mac_source_bits_nonce,
    output logic [MSG_W-1:0]   io_mac_source_bits_msg,
    input  logic [TAG_W-1:0]   io_mac_tag_bits,
    input  logic               io_mac_tag_valid,
    output logic               io_mac_tag_ready,
    output logic               io_resp_valid,
    input  logic               io_resp_ready,
    output logic               io_resp_bits_ok,
    output logic               io_resp_bits_timeout,
    output logic [TAG_W-1:0]   io_resp_bits_tag,
    output logic [15:0]        io_failCount,
    output logic               io_staleDrop
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               rdy_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [TAG_W-1:0]   stored_q, stored_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic               ok_q, ok_d;
    logic               tmo_q, tmo_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [15:0]        fail_cnt_q, fail_cnt_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nonce_d    = nonce_q;
        msg_d      = msg_q;
        stored_d   = stored_q;
        wait_cnt_d = wait_cnt_q;
        ok_d       = ok_q;
        tmo_d      = tmo_q;
        tag_d      = tag_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rdy_q && io_req_valid) begin
                    addr_d   = io_req_bits_addr;
                    nonce_d  = io_req_bits_nonce;
                    msg_d    = io_req_bits_msg;
                    stored_d = io_req_bits_tag;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A tag on the final wait cycle takes priority over the timeout.
                if (io_mac_tag_valid) begin
                    tag_d   = io_mac_tag_bits;
                    ok_d    = (io_mac_tag_bits == stored_q);
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tag_d   = '0;
                    ok_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (io_resp_ready) begin
                    state_d = ST_IDLE;
                    if (!ok_q && fail_cnt_q != 16'hFFFF) begin
                        fail_cnt_d = fail_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            addr_q     <= '0;
            nonce_q    <= '0;
            msg_q      <= '0;
            stored_q   <= '0;
            wait_cnt_q <= '0;
            ok_q       <= 1'b0;
            tmo_q      <= 1'b0;
            tag_q      <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            addr_q     <= addr_d;
            nonce_q    <= nonce_d;
            msg_q      <= msg_d;
            stored_q   <= stored_d;
            wait_cnt_q <= wait_cnt_d;
            ok_q       <= ok_d;
            tmo_q      <= tmo_d;
            tag_q      <= tag_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Tags arriving outside WAIT (e.g. late after a timeout) are accepted and dropped.
    assign io_req_ready             = rdy_q && (state_q == ST_IDLE);
    assign io_mac_tag_ready         = rdy_q;
    assign io_mac_source_valid      = (state_q == ST_ISSUE);
    assign io_mac_source_bits_addr  = addr_q;
    assign io_mac_source_bits_nonce = nonce_q;
    assign io_mac_source_bits_msg   = msg_q;
    assign io_resp_valid            = (state_q == ST_RESP);
    assign io_resp_bits_ok          = ok_q;
    assign io_resp_bits_timeout     = tmo_q;
    assign io_resp_bits_tag         = tag_q;
    assign io_failCount             = fail_cnt_q;
    assign io_staleDrop             = rdy_q && io_mac_tag_valid && (state_q != ST_WAIT);

endmodule

// File: tb/tb_cwmac_tag_verifier.sv
// Bench for cwmac_tag_verifier: directed vectors from the test plan plus randomized
// transactions scored against a transaction-level latency/result model.
module tb_cwmac_tag_verifier;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [25:0]  req_addr = '0;
  logic [55:0]  req_nonce = '0;
  logic [511:0] req_msg = '0;
  logic [55:0]  req_tag = '0;
  logic         src_valid;
  logic [25:0]  src_addr;
  logic [55:0]  src_nonce;
  logic [511:0] src_msg;
  logic [55:0]  mac_tag = '0;
  logic         mac_valid = 1'b0;
  logic         mac_ready;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_ok;
  logic         resp_tmo;
  logic [55:0]  resp_tag;
  logic [15:0]  fail_count;
  logic         stale_drop;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_fail = '0;

  cwmac_tag_verifier #(.TIMEOUT(TMO)) dut (
    .clock                    (clk),
    .reset                    (rst),
    .io_req_valid             (req_valid),
    .io_req_ready             (req_ready),
    .io_req_bits_addr         (req_addr),
    .io_req_bits_nonce        (req_nonce),
    .io_req_bits_msg          (req_msg),
    .io_req_bits_tag          (req_tag),
    .io_mac_source_valid      (src_valid),
    .io_mac_source_bits_addr  (src_addr),
    .io_mac_source_bits_nonce (src_nonce),
    .io_mac_source_bits_msg   (src_msg),
    .io_mac_tag_bits          (mac_tag),
    .io_mac_tag_valid         (mac_valid),
    .io_mac_tag_ready         (mac_ready),
    .io_resp_valid            (resp_valid),
    .io_resp_ready            (resp_ready),
    .io_resp_bits_ok          (resp_ok),
    .io_resp_bits_timeout     (resp_tmo),
    .io_resp_bits_tag         (resp_tag),
    .io_failCount             (fail_count),
    .io_staleDrop             (stale_drop)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // One full transaction, entered and left at a negedge with the DUT idle.
  // k = WAIT cycle index (0-based) on which the MAC returns mt; k >= TMO means never.
  task automatic run_txn(input logic [25:0] a, input logic [55:0] n, input logic [511:0] m,
                         input logic [55:0] st, input logic [55:0] mt, input int k,
                         input int bp, input bit stale_issue, input bit stale_resp);
    bit          exp_tmo;
    bit          exp_ok;
    int          exp_lat;
    logic [55:0] exp_tag;
    bit          seen;
    int          lat;
    exp_tmo = (k >= TMO);
    exp_ok  = !exp_tmo && (mt == st);
    exp_lat = exp_tmo ? TMO : k + 1;
    exp_tag = exp_tmo ? 56'h0 : mt;

    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = a; req_nonce = n; req_msg = m; req_tag = st;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("src_valid", src_valid, 1'b1);
    check_eq("src_addr", src_addr, a);
    check_eq("src_nonce", src_nonce, n);
    check_eq("src_msg", src_msg, m);
    check_eq("req_ready_busy", req_ready, 1'b0);
    if (stale_issue) begin
      mac_valid = 1'b1; mac_tag = 56'($urandom);
      #1 check_eq("stale_issue", stale_drop, 1'b1);
    end

    seen = 1'b0; lat = 0;
    for (int c = 0; c <= TMO + 2; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("src_pulse_once", src_valid, 1'b0);
      if (resp_valid) begin
        seen = 1'b1; lat = c;
        break;
      end
      mac_valid = (c == k);
      mac_tag   = mt;
    end
    mac_valid = 1'b0;
    check_eq("resp_seen", seen, 1'b1);
    check_eq("resp_latency", lat, exp_lat);
    check_eq("resp_ok", resp_ok, exp_ok);
    check_eq("resp_timeout", resp_tmo, exp_tmo);
    check_eq("resp_tag", resp_tag, exp_tag);

    for (int b = 0; b < bp; b++) begin
      resp_ready = 1'b0;
      req_valid = 1'b1; req_addr = ~a; req_tag = ~st;
      if (stale_resp && b == 0) begin
        mac_valid = 1'b1; mac_tag = ~mt;
        #1 check_eq("stale_resp", stale_drop, 1'b1);
      end
      @(negedge clk);
      mac_valid = 1'b0;
      check_eq("bp_valid", resp_valid, 1'b1);
      check_eq("bp_ok", resp_ok, exp_ok);
      check_eq("bp_timeout", resp_tmo, exp_tmo);
      check_eq("bp_tag", resp_tag, exp_tag);
      check_eq("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (!exp_ok && exp_fail != 16'hFFFF) exp_fail = exp_fail + 16'd1;
    check_eq("post_req_ready", req_ready, 1'b1);
    check_eq("post_resp_valid", resp_valid, 1'b0);
    check_eq("fail_count", fail_count, exp_fail);
  endtask

  initial begin
    logic [511:0] kv_msg;
    logic [55:0]  st;
    logic [55:0]  mt;
    bit           any_resp;
    kv_msg = '0;
    kv_msg[495:480] = 16'h0100;
    kv_msg[15:0]    = 16'h0002;

    // reset state, with a tag arriving while reset is held
    mac_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_mac_ready", mac_ready, 1'b0);
    check_eq("rst_src_valid", src_valid, 1'b0);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_fail_count", fail_count, 16'h0);
    check_eq("rst_stale", stale_drop, 1'b0);
    mac_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", req_ready, 1'b1);
    check_eq("post_rst_mac_ready", mac_ready, 1'b1);

    // known vector: match, then mismatch
    run_txn(26'h11ffe00, 56'h2, kv_msg, 56'h9d906ad9445061, 56'h9d906ad9445061, 1, 0, 0, 0);
    run_txn(26'h11ffe00, 56'h2, kv_msg, 56'h9d906ad9445060, 56'h9d906ad9445061, 1, 0, 0, 0);

    // timeout, then a late tag three cycles after the handshake
    run_txn(26'h0000123, 56'h77, rand_msg(), 56'h1234, 56'h1234, 1000, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    mac_valid = 1'b1; mac_tag = 56'h1234;
    #1 check_eq("late_stale", stale_drop, 1'b1);
    check_eq("late_req_ready", req_ready, 1'b1);
    @(negedge clk);
    mac_valid = 1'b0;
    #1 check_eq("late_stale_clear", stale_drop, 1'b0);
    check_eq("late_still_idle", req_ready, 1'b1);
    check_eq("late_fail_count", fail_count, exp_fail);

    // backpressure with a stale tag during RESP; tag/timeout tie both ways
    run_txn(26'h2aaaaaa, 56'h5, rand_msg(), 56'hab, 56'hab, 0, 5, 1, 1);
    run_txn(26'h0155555, 56'h6, rand_msg(), 56'hcd, 56'hcd, TMO - 1, 0, 0, 0);
    run_txn(26'h0155555, 56'h6, rand_msg(), 56'hcd, 56'hce, TMO - 1, 1, 0, 0);

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      st = {24'($urandom), 32'($urandom)};
      case ($urandom_range(0, 2))
        0:       mt = st;
        1:       mt = st ^ (56'h1 << $urandom_range(0, 55));
        default: mt = {24'($urandom), 32'($urandom)};
      endcase
      run_txn(26'($urandom), {24'($urandom), 32'($urandom)}, rand_msg(), st, mt,
              $urandom_range(0, TMO + 1), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset while in WAIT
    req_valid = 1'b1; req_addr = 26'h3; req_nonce = 56'h3; req_msg = rand_msg(); req_tag = 56'h3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_req_ready", req_ready, 1'b0);
    check_eq("midrst_mac_ready", mac_ready, 1'b0);
    check_eq("midrst_fail_count", fail_count, 16'h0);
    rst = 1'b0;
    exp_fail = '0;
    @(negedge clk);
    check_eq("midrst_release_ready", req_ready, 1'b1);
    any_resp = 1'b0;
    for (int c = 0; c < TMO + 4; c++) begin
      @(negedge clk);
      if (resp_valid || src_valid) any_resp = 1'b1;
    end
    check_eq("midrst_no_resp", any_resp, 1'b0);

    // saturation: preload to FFFE while idle, then three mismatches
    force dut.fail_cnt_q = 16'hFFFE;
    @(negedge clk);
    @(negedge clk);
    release dut.fail_cnt_q;
    exp_fail = 16'hFFFE;
    @(negedge clk);
    check_eq("preload_fail_count", fail_count, exp_fail);
    for (int t = 0; t < 3; t++) begin
      run_txn(26'($urandom), 56'h9, rand_msg(), 56'h10, 56'h11, 0, 0, 0, 0);
    end
    check_eq("sat_fail_count", fail_count, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
